// File: rtl/test_mon_pkg.sv
// Shared constants for the bus write monitor: default widths and FSM encoding.
package test_mon_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_TO_W   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/test_monitor_exp_table.sv
// Expected-write table: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module exp_table
  import test_mon_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int ENT_W = 1 + ADDR_W + DATA_W
) (
  input  logic              ph1,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic              wany,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rany,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ENT_W-1:0] mem [DEPTH];

  always_ff @(posedge ph1) begin
    if (we) mem[widx] <= {wany, waddr, wdata};
  end

  assign {rany, raddr, rdata} = mem[ridx];

endmodule

// File: rtl/test_monitor.sv
// Watches memory writes on a CPU bus and checks them in order against a
// programmed list of expected {address, data} entries, with an optional timeout.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | counting cycles, matching writes against entry[matched]
// PASS  | all expected writes seen
// FAIL  | timeout, or mismatching write when STRICT
module test_monitor
  import test_mon_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TO_W   = DEF_TO_W,
  parameter int STRICT = 0,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_anyaddr,
  input  logic [IDX_W:0]    exp_count,
  input  logic [TO_W-1:0]   timeout,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [7:0]        err_count,
  output logic [IDX_W:0]    matched,
  output logic [TO_W-1:0]   cycles,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [DATA_W-1:0] bad_data
);

  logic [1:0]        state;
  logic              t_any;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_data;
  logic [IDX_W:0]    eff_count;
  logic [IDX_W:0]    matched_inc;
  logic              hit;
  logic              miss;
  logic              last_hit;
  logic              tmo;

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_exp_table (
    .ph1   (ph1),
    .we    (cfg_we && (state != ST_RUN)),
    .widx  (cfg_idx),
    .wany  (cfg_anyaddr),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .ridx  (matched[IDX_W-1:0]),
    .rany  (t_any),
    .raddr (t_addr),
    .rdata (t_data)
  );

  // Case-equality so an X/Z on the observed bus never counts as a match.
  always_comb begin
    eff_count   = (exp_count > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : exp_count;
    matched_inc = matched + (IDX_W+1)'(1);
    hit         = (memwrite === 1'b1) && (t_any || (dataadr === t_addr))
                  && (writedata === t_data);
    miss        = (memwrite === 1'b1) && !hit;
    last_hit    = hit && (matched_inc >= eff_count);
    tmo         = (timeout != '0) && (cycles == timeout - TO_W'(1));
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= ST_IDLE;
      timed_out <= 1'b0;
      err_count <= '0;
      matched   <= '0;
      cycles    <= '0;
      bad_addr  <= '0;
      bad_data  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (last_hit) begin
            matched <= matched_inc;
            cycles  <= cycles + TO_W'(1);
            state   <= ST_PASS;
          end else begin
            if (hit) matched <= matched_inc;
            // A strict mismatch ends the run, so the captured values are always the first.
            if (miss && (STRICT != 0)) begin
              err_count <= sat_inc8(err_count);
              bad_addr  <= dataadr;
              bad_data  <= writedata;
              state     <= ST_FAIL;
            end
            if (tmo) begin
              timed_out <= 1'b1;
              state     <= ST_FAIL;
            end else begin
              cycles <= cycles + TO_W'(1);
            end
          end
        end
        default: begin
          if (start) begin
            timed_out <= 1'b0;
            err_count <= '0;
            matched   <= '0;
            cycles    <= '0;
            bad_addr  <= '0;
            bad_data  <= '0;
            state     <= (exp_count == '0) ? ST_PASS : ST_RUN;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_PASS) || (state == ST_FAIL);
  assign pass = (state == ST_PASS);

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, write data width.
REQ-003 SHALL have parameter DEPTH, default 8, number of expected-write entries; IDX_W = clog2(DEPTH).
REQ-004 SHALL have parameter TO_W, default 16, timeout/cycle counter width.
REQ-005 SHALL have parameter STRICT, default 0; 1 means any non-matching write is an error, 0 means it is ignored.
REQ-006 SHALL use one clock and a synchronous, active-high reset: ph1 input 1 (sole clock, rising edge); reset input 1 (synchronous, active-high).
REQ-007 SHALL have the following config ports: cfg_we input 1, entry write strobe; cfg_idx input IDX_W, entry index; cfg_addr input ADDR_W, expected address; cfg_data input DATA_W, expected data; cfg_anyaddr input 1, entry matches on data only.
REQ-008 SHALL have the following run-control ports: exp_count input IDX_W+1, entries to match; timeout input TO_W, cycle limit; start input 1, begin run.
REQ-009 SHALL have the following bus-observation ports: memwrite input 1; dataadr input ADDR_W; writedata input DATA_W.
REQ-010 SHALL have the following status ports: busy output 1; done output 1; pass output 1; timed_out output 1; err_count output 8; matched output IDX_W+1; cycles output TO_W; bad_addr output ADDR_W; bad_data output DATA_W.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, PASS, FAIL.
REQ-012 SHALL, in IDLE, PASS or FAIL, take start to RUN next cycle: clear matched, cycles, err_count, timed_out, bad_addr and bad_data.
REQ-013 SHALL, when start is asserted with exp_count==0, go directly to PASS next cycle.
REQ-014 SHALL, in RUN, increment cycles by one per cycle.
REQ-015 SHALL, in RUN with memwrite==1, compare against entry[matched]; match = (cfg_anyaddr flag set or dataadr==addr) and writedata==data, with X/Z on the bus counting as mismatch.
REQ-016 SHALL, on a match, increment matched; when matched reaches exp_count, go to PASS next cycle.
REQ-017 SHALL, on a mismatch with STRICT=1, saturating-increment err_count and go to FAIL; with STRICT=0, ignore the write and leave state unchanged.
REQ-018 SHALL capture the first mismatching dataadr/writedata into bad_addr/bad_data; later mismatches SHALL not overwrite them.
REQ-019 SHALL, in RUN when cycles==timeout-1 without completion, go to FAIL and set timed_out; timeout==0 SHALL disable the timeout.
REQ-020 SHALL, when the final match and the timeout occur in the same cycle, give the match priority: PASS, timed_out=0.
REQ-021 SHALL make all status updates visible one ph1 cycle after the sampled write.
REQ-022 SHALL drive busy=1 in RUN only; done=1 in PASS or FAIL; pass=1 in PASS only.
REQ-023 SHALL honour cfg_we only outside RUN; writes during RUN SHALL be dropped.
REQ-024 SHALL treat exp_count>DEPTH as DEPTH.
REQ-025 SHALL ignore start while in RUN.

Reset
REQ-026 SHALL, with reset high at a ph1 edge, enter IDLE and clear every output: busy, done, pass, timed_out, err_count, matched, cycles, bad_addr, bad_data = 0.
REQ-027 SHALL, on reset in RUN, abort the run without reaching PASS or FAIL.
REQ-028 SHALL leave expected-table contents unaffected by reset (undefined until written).

Structure
REQ-029 SHALL place the FSM state encoding and default parameter constants in shared package test_mon_pkg.
REQ-030 SHALL implement the expected table as sub-module exp_table (DEPTH x {anyaddr, addr, data}, one write port, one asynchronous read port).

Verification
REQ-031 SHALL cover: entry0 = {0x14, 21}, exp_count=1, write 21@0x14 at cycle 5 -> pass=1, matched=1, cycles=6.
REQ-032 SHALL cover: STRICT=0, entries {0x0,4} and {0x4,4}, stray write 7@0x200 between them -> pass=1, err_count=0.
REQ-033 SHALL cover: STRICT=1, entry {0x204, 7}, write 8@0x204 -> FAIL, err_count=1, bad_addr=0x204, bad_data=8.
REQ-034 SHALL cover: anyaddr entry with data 479001600, write at arbitrary address -> pass=1.
REQ-035 SHALL cover: timeout=10, no writes -> FAIL, timed_out=1, cycles=9; final match on cycle 9 instead -> PASS.
REQ-036 SHALL cover: reset asserted mid-RUN, then start with exp_count=0 -> IDLE with all outputs 0, then PASS one cycle after start.
